// File: rtl/rmt_action_pkg.sv
// Shared opcode, field and width definitions for the RMT action crossbar.
// Imported by the crossbar top and its per-lane operand selector.
package rmt_action_pkg;

  localparam int DEF_NUM_CONT = 8;
  localparam int DEF_W_6B     = 48;
  localparam int DEF_W_4B     = 32;
  localparam int DEF_W_2B     = 16;
  localparam int DEF_ACT_LEN  = 25;
  localparam int DEF_META_LEN = 356;

  localparam int OPC_LSB = 21;
  localparam int OPC_W   = 4;
  localparam int OP1_LSB = 16;
  localparam int OP2_LSB = 11;
  localparam int IDX_W   = 3;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SET   = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_LOADD = 4'b1011;

  typedef enum logic [1:0] {
    K_PASS,
    K_REG,
    K_IMM,
    K_BAD
  } op_kind_e;

  // ext enables the 4B-only immediate opcodes
  function automatic op_kind_e op_kind(
    input logic [3:0] opc,
    input logic       ext
  );
    op_kind_e k;
    case (opc)
      OP_NOP:            k = K_PASS;
      OP_ADD, OP_SUB:    k = K_REG;
      OP_ADDI, OP_SUBI:  k = K_IMM;
      OP_SET, OP_LOADD:  k = ext ? K_IMM : K_BAD;
      default:           k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/xbar_lane_sel.sv
// Operand selector for one container lane of one width class.
// Falls back to passthrough on illegal opcode or out-of-range index.
module xbar_lane_sel
  import rmt_action_pkg::*;
#(
  parameter int W        = DEF_W_2B,
  parameter int NUM_CONT = DEF_NUM_CONT,
  parameter int LANE     = 0,
  parameter int ACT_LEN  = DEF_ACT_LEN,
  parameter bit EXT_IMM  = 1'b0
) (
  input  logic [W*NUM_CONT-1:0] cont,
  input  logic [ACT_LEN-1:0]    act,
  input  logic                  act_valid,
  output logic [W-1:0]          op1,
  output logic [W-1:0]          op2,
  output logic                  illegal
);

  logic [OPC_W-1:0] opc;
  logic [IDX_W-1:0] i1;
  logic [IDX_W-1:0] i2;
  logic [IMM_W-1:0] imm;
  op_kind_e         kind;
  logic             r1;
  logic             r2;
  logic             unused_rsvd;

  assign opc  = act[OPC_LSB +: OPC_W];
  assign i1   = act[OP1_LSB +: IDX_W];
  assign i2   = act[OP2_LSB +: IDX_W];
  assign imm  = act[IMM_LSB +: IMM_W];
  assign kind = op_kind(opc, EXT_IMM);
  assign r1   = int'(i1) < NUM_CONT;
  assign r2   = int'(i2) < NUM_CONT;

  assign unused_rsvd = ^act[20:19];

  always_comb begin
    op1     = cont[LANE*W +: W];
    op2     = '0;
    illegal = 1'b0;
    if (act_valid) begin
      unique case (1'b1)
        kind == K_PASS: begin
        end
        kind == K_REG && r1 && r2: begin
          op1 = cont[i1*W +: W];
          op2 = cont[i2*W +: W];
        end
        kind == K_IMM && r1: begin
          op1 = cont[i1*W +: W];
          op2 = W'(imm);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/action_crossbar_p.sv
// Action crossbar: splits the PHV into per-class containers and selects
// ALU operands per lane, behind a one-entry skid buffer.
module action_crossbar_p
  import rmt_action_pkg::*;
#(
  parameter int NUM_CONT = DEF_NUM_CONT,
  parameter int W_6B     = DEF_W_6B,
  parameter int W_4B     = DEF_W_4B,
  parameter int W_2B     = DEF_W_2B,
  parameter int ACT_LEN  = DEF_ACT_LEN,
  parameter int META_LEN = DEF_META_LEN,
  localparam int PHV_LEN =
    NUM_CONT*(W_6B+W_4B+W_2B)+META_LEN,
  localparam int NUM_SLOT = 3*NUM_CONT+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PHV_LEN-1:0]          phv_in,
  input  logic                        phv_in_valid,
  output logic                        phv_in_ready,
  input  logic [ACT_LEN*NUM_SLOT-1:0] action_in,
  input  logic                        action_in_valid,
  output logic                        alu_in_valid,
  input  logic                        alu_in_ready,
  output logic [W_6B*NUM_CONT-1:0]    alu_in_6B_1,
  output logic [W_6B*NUM_CONT-1:0]    alu_in_6B_2,
  output logic [W_4B*NUM_CONT-1:0]    alu_in_4B_1,
  output logic [W_4B*NUM_CONT-1:0]    alu_in_4B_2,
  output logic [W_4B*NUM_CONT-1:0]    alu_in_4B_3,
  output logic [W_2B*NUM_CONT-1:0]    alu_in_2B_1,
  output logic [W_2B*NUM_CONT-1:0]    alu_in_2B_2,
  output logic [META_LEN-1:0]         phv_remain_data,
  output logic [15:0]                 illegal_op_cnt
);

  localparam int L6 = W_6B*NUM_CONT;
  localparam int L4 = W_4B*NUM_CONT;
  localparam int L2 = W_2B*NUM_CONT;
  localparam int BW = 2*L6+3*L4+2*L2+META_LEN;

  logic [L6-1:0] c6, o61, o62;
  logic [L4-1:0] c4, o41, o42;
  logic [L2-1:0] c2, o21, o22;
  logic [3*NUM_CONT-1:0] ill;
  logic [BW-1:0] beat_d;
  logic [BW-1:0] out_q;
  logic [BW-1:0] skid_q;
  logic out_valid;
  logic skid_full;
  logic skid_nxt;
  logic ready_q;
  logic acc;
  logic out_free;
  logic unused_slot0;

  assign c6 = phv_in[PHV_LEN-1 -: L6];
  assign c4 = phv_in[META_LEN+L2 +: L4];
  assign c2 = phv_in[META_LEN +: L2];

  assign unused_slot0 = ^action_in[ACT_LEN-1:0];

  for (genvar i = 0; i < NUM_CONT; i++) begin : g_lane
    xbar_lane_sel #(
      .W(W_2B), .NUM_CONT(NUM_CONT), .LANE(i),
      .ACT_LEN(ACT_LEN), .EXT_IMM(1'b0)
    ) u_2b (
      .cont(c2),
      .act(action_in[(1+i)*ACT_LEN +: ACT_LEN]),
      .act_valid(action_in_valid),
      .op1(o21[i*W_2B +: W_2B]),
      .op2(o22[i*W_2B +: W_2B]),
      .illegal(ill[i])
    );
    xbar_lane_sel #(
      .W(W_4B), .NUM_CONT(NUM_CONT), .LANE(i),
      .ACT_LEN(ACT_LEN), .EXT_IMM(1'b1)
    ) u_4b (
      .cont(c4),
      .act(action_in[(NUM_CONT+1+i)*ACT_LEN +: ACT_LEN]),
      .act_valid(action_in_valid),
      .op1(o41[i*W_4B +: W_4B]),
      .op2(o42[i*W_4B +: W_4B]),
      .illegal(ill[NUM_CONT+i])
    );
    xbar_lane_sel #(
      .W(W_6B), .NUM_CONT(NUM_CONT), .LANE(i),
      .ACT_LEN(ACT_LEN), .EXT_IMM(1'b0)
    ) u_6b (
      .cont(c6),
      .act(action_in[(2*NUM_CONT+1+i)*ACT_LEN +: ACT_LEN]),
      .act_valid(action_in_valid),
      .op1(o61[i*W_6B +: W_6B]),
      .op2(o62[i*W_6B +: W_6B]),
      .illegal(ill[2*NUM_CONT+i])
    );
  end

  assign beat_d = {o61, o62, o41, o42, c4, o21, o22,
                   phv_in[META_LEN-1:0]};

  assign acc      = phv_in_valid & ready_q;
  assign out_free = ~out_valid | alu_in_ready;
  // ready is registered, so skid is never full when a beat is accepted
  assign skid_nxt = out_free ? 1'b0 : (skid_full | acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q          <= '0;
      skid_q         <= '0;
      out_valid      <= 1'b0;
      skid_full      <= 1'b0;
      ready_q        <= 1'b0;
      illegal_op_cnt <= '0;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
        end else begin
          out_valid <= acc;
          if (acc) out_q <= beat_d;
        end
      end else if (acc) begin
        skid_q <= beat_d;
      end
      skid_full <= skid_nxt;
      ready_q   <= ~skid_nxt;
      if (acc && (|ill) && illegal_op_cnt != 16'hFFFF)
        illegal_op_cnt <= illegal_op_cnt + 16'd1;
    end
  end

  assign phv_in_ready = ready_q;
  assign alu_in_valid = out_valid;
  assign {alu_in_6B_1, alu_in_6B_2,
          alu_in_4B_1, alu_in_4B_2, alu_in_4B_3,
          alu_in_2B_1, alu_in_2B_2,
          phv_remain_data} = out_q;

endmodule
